// File: rtl/dt_param.sv
// dt_param: two-pass distance-transform engine.
// Reads a packed binary image from the STI ROM (MSB of each word is the
// leftmost pixel) and writes a saturating chessboard or city-block
// distance map to the RES RAM. Every pixel is written in the forward
// pass. The backward pass only rewrites interior pixels that shrink.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, mode       run request (IDLE only); mode 0 chessboard, 1 city-block
//   busy, done        run in progress / run complete (held until next start)
//   sti_rd, sti_addr  STI word read strobe and address; sti_di one cycle later
//   res_rd, res_wr    RES read / write strobes sharing res_addr
//   res_do, res_di    RES write data / read data (one cycle after res_rd)
module dt_param #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int WORD_W = 16,
  parameter int DIST_W = 8,
  parameter int STI_AW = $clog2(IMG_W*IMG_H/WORD_W),
  parameter int RES_AW = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              sti_rd,
  output logic [STI_AW-1:0] sti_addr,
  input  logic [WORD_W-1:0] sti_di,
  output logic              res_rd,
  output logic              res_wr,
  output logic [RES_AW-1:0] res_addr,
  output logic [DIST_W-1:0] res_do,
  input  logic [DIST_W-1:0] res_di
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [XW-1:0]     XMAX       = XW'(IMG_W-1);
  localparam logic [YW-1:0]     YMAX       = YW'(IMG_H-1);
  localparam logic [BW-1:0]     BMAX       = BW'(WORD_W-1);
  localparam logic [RES_AW-1:0] ONE        = RES_AW'(1);
  localparam logic [RES_AW-1:0] ROW        = RES_AW'(IMG_W);
  localparam logic [RES_AW-1:0] PIX_LAST   = RES_AW'(IMG_W*IMG_H-1);
  localparam logic [RES_AW-1:0] PIX_BSTART = RES_AW'((IMG_H-2)*IMG_W + IMG_W-2);
  localparam logic [DIST_W-1:0] DMAX       = '1;
  localparam logic [DIST_W:0]   DMAX1      = {1'b0, DMAX};

  typedef enum logic [3:0] {
    IDLE, F_FETCH, F_PIX, F_NBR, F_WR, B_CTR, B_NBR, B_WR, FIN
  } state_t;

  state_t              state_q;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic [RES_AW-1:0]   pix_q;
  logic [BW-1:0]       bit_q;
  logic [WORD_W-1:0]   word_q;
  logic                mode_q;
  logic [2:0]          ph_q;
  logic [DIST_W-1:0]   nbrMin_q;
  logic [DIST_W-1:0]   ctr_q;
  logic                busy_q, done_q, stiRd_q, resRd_q, resWr_q;
  logic [STI_AW-1:0]   stiAddr_q;
  logic [RES_AW-1:0]   resAddr_q;
  logic [DIST_W-1:0]   resDo_q;

  logic [2:0]          nNbr_d;
  logic [DIST_W-1:0]   minNbr_d;
  logic [DIST_W:0]     sum_d;
  logic [DIST_W-1:0]   fwdVal_d;
  logic                bwdWr_d;
  logic                border_d;
  logic                obj_d;
  logic                bwdStep_d;
  logic [RES_AW-1:0]   bwdNextPix_d;

  assign busy     = busy_q;
  assign done     = done_q;
  assign sti_rd   = stiRd_q;
  assign sti_addr = stiAddr_q;
  assign res_rd   = resRd_q;
  assign res_wr   = resWr_q;
  assign res_addr = resAddr_q;
  assign res_do   = resDo_q;

  // Neighbour k of the current pixel. Forward reads W, NW, N, NE (city: W, N)
  // at base-d; the backward pass mirrors them to E, SE, S, SW (city: E, S)
  // at base+d using the same offset table.
  function automatic logic [RES_AW-1:0] nbrAddr(input logic [RES_AW-1:0] base,
                                                input logic [2:0] k,
                                                input logic city,
                                                input logic back);
    logic [RES_AW-1:0] d;
    if (k == 3'd0)                d = ONE;
    else if (city || k == 3'd2)   d = ROW;
    else if (k == 3'd1)           d = ROW + ONE;
    else                          d = ROW - ONE;
    return back ? (base + d) : (base - d);
  endfunction

  // Running minimum, the widened +1 sum and the decisions taken from them.
  // minNbr_d folds in the read data arriving this cycle.
  always_comb begin
    nNbr_d       = mode_q ? 3'd2 : 3'd4;
    minNbr_d     = (res_di < nbrMin_q) ? res_di : nbrMin_q;
    sum_d        = {1'b0, minNbr_d} + (DIST_W+1)'(1);
    fwdVal_d     = (sum_d > DMAX1) ? DMAX : sum_d[DIST_W-1:0];
    bwdWr_d      = sum_d < {1'b0, ctr_q};
    border_d     = (x_q == '0) || (y_q == '0) || (x_q == XMAX) || (y_q == YMAX);
    obj_d        = word_q[WORD_W-1] && !border_d;
    bwdNextPix_d = (x_q == XW'(1)) ? (pix_q - RES_AW'(3)) : (pix_q - ONE);
    bwdStep_d    = ((state_q == B_CTR) && (ph_q == 3'd1) && (res_di == '0)) ||
                   ((state_q == B_NBR) && (ph_q == nNbr_d) && !bwdWr_d) ||
                   (state_q == B_WR);
  end

  // Main sequencer. Strobes default low so each is a one-cycle pulse.
  // Reads are pipelined: read k is strobed in phase k and its data is
  // folded into the minimum at the end of phase k+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      pix_q     <= '0;
      bit_q     <= '0;
      word_q    <= '0;
      mode_q    <= 1'b0;
      ph_q      <= '0;
      nbrMin_q  <= '0;
      ctr_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      stiRd_q   <= 1'b0;
      resRd_q   <= 1'b0;
      resWr_q   <= 1'b0;
      stiAddr_q <= '0;
      resAddr_q <= '0;
      resDo_q   <= '0;
    end else begin
      stiRd_q <= 1'b0;
      resRd_q <= 1'b0;
      resWr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            pix_q     <= '0;
            bit_q     <= '0;
            ph_q      <= '0;
            stiAddr_q <= '0;
            stiRd_q   <= 1'b1;
            state_q   <= F_FETCH;
          end
        end
        F_FETCH: begin
          if (ph_q == 3'd0) begin
            ph_q <= 3'd1;
          end else begin
            word_q  <= sti_di;
            state_q <= F_PIX;
          end
        end
        F_PIX: begin
          if (obj_d) begin
            nbrMin_q  <= '1;
            ph_q      <= '0;
            resRd_q   <= 1'b1;
            resAddr_q <= nbrAddr(pix_q, 3'd0, mode_q, 1'b0);
            state_q   <= F_NBR;
          end else begin
            resWr_q   <= 1'b1;
            resAddr_q <= pix_q;
            resDo_q   <= '0;
            state_q   <= F_WR;
          end
        end
        F_NBR: begin
          if (ph_q == nNbr_d) begin
            resWr_q   <= 1'b1;
            resAddr_q <= pix_q;
            resDo_q   <= fwdVal_d;
            state_q   <= F_WR;
          end else begin
            if (ph_q != 3'd0) nbrMin_q <= minNbr_d;
            if ((ph_q + 3'd1) < nNbr_d) begin
              resRd_q   <= 1'b1;
              resAddr_q <= nbrAddr(pix_q, ph_q + 3'd1, mode_q, 1'b0);
            end
            ph_q <= ph_q + 3'd1;
          end
        end
        F_WR: begin
          if (pix_q == PIX_LAST) begin
            x_q       <= XW'(IMG_W-2);
            y_q       <= YW'(IMG_H-2);
            pix_q     <= PIX_BSTART;
            ph_q      <= '0;
            resRd_q   <= 1'b1;
            resAddr_q <= PIX_BSTART;
            state_q   <= B_CTR;
          end else begin
            pix_q  <= pix_q + ONE;
            word_q <= word_q << 1;
            if (x_q == XMAX) begin
              x_q <= '0;
              y_q <= y_q + YW'(1);
            end else begin
              x_q <= x_q + XW'(1);
            end
            if (bit_q == BMAX) begin
              bit_q     <= '0;
              ph_q      <= '0;
              stiAddr_q <= stiAddr_q + STI_AW'(1);
              stiRd_q   <= 1'b1;
              state_q   <= F_FETCH;
            end else begin
              bit_q   <= bit_q + BW'(1);
              state_q <= F_PIX;
            end
          end
        end
        B_CTR: begin
          if (ph_q == 3'd0) begin
            ph_q <= 3'd1;
          end else if (res_di != '0) begin
            ctr_q     <= res_di;
            nbrMin_q  <= '1;
            ph_q      <= '0;
            resRd_q   <= 1'b1;
            resAddr_q <= nbrAddr(pix_q, 3'd0, mode_q, 1'b1);
            state_q   <= B_NBR;
          end
        end
        B_NBR: begin
          if (ph_q == nNbr_d) begin
            if (bwdWr_d) begin
              resWr_q   <= 1'b1;
              resAddr_q <= pix_q;
              resDo_q   <= sum_d[DIST_W-1:0];
              state_q   <= B_WR;
            end
          end else begin
            if (ph_q != 3'd0) nbrMin_q <= minNbr_d;
            if ((ph_q + 3'd1) < nNbr_d) begin
              resRd_q   <= 1'b1;
              resAddr_q <= nbrAddr(pix_q, ph_q + 3'd1, mode_q, 1'b1);
            end
            ph_q <= ph_q + 3'd1;
          end
        end
        B_WR: begin
          state_q <= B_WR;
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Step to the previous interior pixel (or finish after (1,1)); this
      // overrides the per-state assignments above on the cycles it fires.
      if (bwdStep_d) begin
        if ((x_q == XW'(1)) && (y_q == YW'(1))) begin
          state_q <= FIN;
        end else begin
          if (x_q == XW'(1)) begin
            x_q <= XW'(IMG_W-2);
            y_q <= y_q - YW'(1);
          end else begin
            x_q <= x_q - XW'(1);
          end
          pix_q     <= bwdNextPix_d;
          ph_q      <= '0;
          resRd_q   <= 1'b1;
          resAddr_q <= bwdNextPix_d;
          state_q   <= B_CTR;
        end
      end
    end
  end

endmodule

// File: doc/dt_param.md
# dt_param

Parameterised two-pass distance-transform engine, the successor to our fixed 128x128 chessboard DT block. It reads a packed binary image from the STI ROM and writes a per-pixel distance map to the RES RAM. Image size, packing width and distance width are generics, and a run-time mode selects the chessboard (8-neighbour) or city-block (4-neighbour) metric. Unlike its predecessor it is start-triggered and re-runnable, writes every pixel so RES needs no pre-clear, and saturates distances instead of wrapping.

## Interface
- IMG_W, 128: image width in pixels; must be a multiple of WORD_W, at least 4
- IMG_H, 128: image height in pixels, at least 3
- WORD_W, 16: pixels per STI word
- DIST_W, 8: distance width; DMAX = 2^DIST_W-1
- STI_AW, derived: clog2(IMG_W*IMG_H/WORD_W)
- RES_AW, derived: clog2(IMG_W*IMG_H)

Ports:
- clk  in  1  sole clock; everything is rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle run request; honoured only in IDLE
- mode  in  1  0 = chessboard, 1 = city-block; sampled on an accepted start
- busy  out  1  high from the cycle after an accepted start until done rises
- done  out  1  held high from completion until the next accepted start or reset
- sti_rd  out  1  STI read strobe
- sti_addr  out  STI_AW  STI word address
- sti_di  in  WORD_W  STI data; valid the cycle after sti_rd
- res_rd  out  1  RES read strobe
- res_wr  out  1  RES write strobe
- res_addr  out  RES_AW  RES address
- res_do  out  DIST_W  RES write data
- res_di  in  DIST_W  RES read data; valid the cycle after res_rd

## Operation
Pixel and address mapping:
- Pixel (x, y) lives at STI word (y*IMG_W+x)/WORD_W, bit WORD_W-1-(x mod WORD_W). The MSB is the leftmost pixel.
- RES address is y*IMG_W+x.
- Border pixels (x=0, y=0, x=IMG_W-1, y=IMG_H-1) are always treated as background, whatever their STI value.

Forward pass (raster order, y from 0 up, x from 0 up; every pixel written):
- Background or border pixel: write 0.
- Object pixel: write sat(1 + min(W, NW, N, NE)) in chessboard mode, or sat(1 + min(W, N)) in city-block mode.
- Neighbour values come from RES reads of previously written pixels.

Backward pass (reverse raster over interior pixels only):
- Read the centre value c. If c = 0, skip the pixel.
- Otherwise compute m = min(c, E+1, SW+1, S+1, SE+1) in chessboard mode, or min(c, E+1, S+1) in city-block mode.
- Write m only if m < c.

Arithmetic:
- Sums are computed at DIST_W+1 bits.
- sat() clamps to DMAX; DMAX+1 is never written.

State machine:
- States: IDLE, F_FETCH, F_PIX, F_NBR, F_WR, B_CTR, B_NBR, B_WR, FIN.
- IDLE to F_FETCH on start.
- F_FETCH issues one STI read per word; the word is held in a shift register and consumed by F_PIX without re-reading.
- F_PIX goes to F_WR for background/border pixels, otherwise to F_NBR (4 or 2 reads), then to F_WR.
- After the last pixel's F_WR: go to B_CTR.
- B_CTR goes to B_NBR when c != 0, else to the next pixel.
- B_NBR goes to B_WR when m < c, else to the next pixel.
- After pixel (1,1): go to FIN.
- FIN sets done, clears busy, and returns to IDLE.

## Timing
- Reset (synchronous, active-high) forces IDLE on that edge. busy, done, sti_rd, res_rd, res_wr, sti_addr, res_addr and res_do all become 0. Reset mid-run abandons the run with no further strobes.
- At most one of sti_rd, res_rd and res_wr is high in any cycle. Each strobe is a single-cycle pulse with its address and data valid in the same cycle.
- Read latency is 1 cycle. The engine samples sti_di/res_di on the edge after the strobe cycle and may issue the next request in that same cycle.
- A RES write in cycle t is assumed visible to a read issued in cycle t+1.
- start while busy is ignored. start in the cycle done rises is ignored. start while done is held high clears done and begins a new run.
- mode is ignored except on the accepted start edge.
- busy rises on the edge after start is sampled, and the first sti_rd occurs in that same cycle.

## Test plan
- All-zero image, IMG_W=16, IMG_H=8 -> exactly 128 forward writes, all 0, and no backward writes. done rises and holds; busy falls the same cycle.
- 16x8 image with interior all ones, chessboard -> RES(x,y) = min(x, 15-x, y, 7-y). (7,3) = 3, (1,1) = 1, border = 0.
- Same image with pixel (8,4) cleared -> chessboard (9,5) = 1; city-block (9,5) = 2, (8,5) = 1.
- 16x16 full interior with DIST_W=2 -> centre (7,7) reads 3 (saturated). No value exceeds 3.
- start pulsed twice mid-run -> second pulse ignored. Reset asserted at cycle 100 -> every output is 0 after that edge. A fresh start then gives the same correct map as an uninterrupted run.
- Protocol monitor on all runs -> strobes mutually exclusive, addresses < 128 (RES) / < 8 (STI) for 16x8, and res_do never above DMAX.
